dance_decoder: RTL and testbench

// Receive end of the LED "dance" position stream. Samples the 5-bit LED index that

---
 rtl/dance_decoder_if.sv | 23 ++
 rtl/dance_decoder.sv | 205 ++++++++++++++++++++
 tb/tb_dance_decoder.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/dance_decoder_if.sv
// Position stream from dance into dance_decoder, plus the decoder's status outputs.
interface dance_decoder_if #(
    parameter int NUM_LEDS = 18,
    parameter int POS_W    = 5
);
    logic                pos_valid;
    logic [POS_W-1:0]    position;
    logic [NUM_LEDS-1:0] led;
    logic [1:0]          mode;
    logic                locked;
    logic                step_err;
    logic [7:0]          err_count;

    modport master (
        output pos_valid, position,
        input  led, mode, locked, step_err, err_count
    );

    modport slave (
        input  pos_valid, position,
        output led, mode, locked, step_err, err_count
    );
endinterface

// File: rtl/dance_decoder.sv
// Rebuilds the LED one-hot from dance's position stream and checks it against the inferred pattern.
// Optional: define DANCE_DEC_ERRCNT_EN for the saturating err_count register (otherwise err_count is 0).
module dance_decoder #(
    parameter int NUM_LEDS   = 18,
    parameter int POS_W      = 5,
    parameter int LOCK_COUNT = 4
) (
    input  logic            clock,
    input  logic            reset,
    dance_decoder_if.slave  bus
);
    localparam int RUN_W = $clog2(LOCK_COUNT + 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ACQ  = 2'd1;
    localparam logic [1:0] ST_LOCK = 2'd2;

    localparam logic [1:0] M_ASC  = 2'd0;
    localparam logic [1:0] M_DESC = 2'd1;
    localparam logic [1:0] M_BNC  = 2'd2;
    localparam logic [1:0] M_NONE = 2'd3;

    localparam logic [2:0] S_REP = 3'd0;
    localparam logic [2:0] S_UP  = 3'd1;
    localparam logic [2:0] S_DN  = 3'd2;
    localparam logic [2:0] S_WUP = 3'd3;
    localparam logic [2:0] S_WDN = 3'd4;
    localparam logic [2:0] S_BAD = 3'd5;

    localparam logic [POS_W:0]    P_ZERO   = (POS_W+1)'(0);
    localparam logic [POS_W:0]    P_ONE    = (POS_W+1)'(1);
    localparam logic [POS_W:0]    P_LAST   = (POS_W+1)'(NUM_LEDS - 1);
    localparam logic [POS_W:0]    P_COUNT  = (POS_W+1)'(NUM_LEDS);
    localparam logic [RUN_W-1:0]  RUN_ZERO = RUN_W'(0);
    localparam logic [RUN_W-1:0]  RUN_ONE  = RUN_W'(1);
    localparam logic [RUN_W-1:0]  RUN_LOCK = RUN_W'(LOCK_COUNT);
    localparam logic [NUM_LEDS-1:0] LED_ONE  = NUM_LEDS'(1);
    localparam logic [NUM_LEDS-1:0] LED_ZERO = NUM_LEDS'(0);

    function automatic logic [2:0] classify(input logic [POS_W:0] p, input logic [POS_W:0] q);
        logic [2:0] c;
        c = S_BAD;
        if (q == p)                          c = S_REP;
        else if (q == p + P_ONE)             c = S_UP;
        else if (p != P_ZERO && q == p - P_ONE) c = S_DN;
        else if (p == P_LAST && q == P_ZERO) c = S_WUP;
        else if (p == P_ZERO && q == P_LAST) c = S_WDN;
        else                                 c = S_BAD;
        return c;
    endfunction

    // Bounce follows the last direction except at the two ends, where it must turn.
    function automatic logic consistent(input logic [1:0] cand, input logic [2:0] cls,
                                        input logic [POS_W:0] p, input logic dir_up);
        logic ok;
        ok = 1'b0;
        case (cand)
            M_ASC:  ok = (cls == S_UP) || (cls == S_WUP);
            M_DESC: ok = (cls == S_DN) || (cls == S_WDN);
            M_BNC: begin
                if (p == P_LAST)      ok = (cls == S_DN);
                else if (p == P_ZERO) ok = (cls == S_UP);
                else                  ok = dir_up ? (cls == S_UP) : (cls == S_DN);
            end
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

    function automatic logic [1:0] seed_mode(input logic [2:0] cls);
        logic [1:0] m;
        case (cls)
            S_UP, S_WUP: m = M_ASC;
            S_DN, S_WDN: m = M_DESC;
            default:     m = M_NONE;
        endcase
        return m;
    endfunction

    logic [1:0]          state_r, state_s;
    logic [POS_W-1:0]    prev_r, prev_s;
    logic [NUM_LEDS-1:0] led_r, led_s;
    logic [1:0]          mode_r, mode_s;
    logic [1:0]          cand_r, cand_s;
    logic [RUN_W-1:0]    run_r, run_s;
    logic                dir_up_r, dir_up_s;
    logic                locked_r, locked_s;
    logic                step_err_r, step_err_s;
    logic [POS_W:0]      p_ext_s, q_ext_s;
    logic [2:0]          cls_s;
    logic                ok_s, upg_s;

    // Next-state decode for one sampled position.
    always_comb begin
        state_s    = state_r;
        prev_s     = prev_r;
        led_s      = led_r;
        mode_s     = mode_r;
        cand_s     = cand_r;
        run_s      = run_r;
        dir_up_s   = dir_up_r;
        locked_s   = locked_r;
        step_err_s = 1'b0;
        p_ext_s    = {1'b0, prev_r};
        q_ext_s    = {1'b0, bus.position};
        cls_s      = classify(p_ext_s, q_ext_s);
        ok_s       = consistent(cand_r, cls_s, p_ext_s, dir_up_r);
        upg_s      = ((cand_r == M_ASC)  && (p_ext_s == P_LAST) && (cls_s == S_DN)) ||
                     ((cand_r == M_DESC) && (p_ext_s == P_ZERO) && (cls_s == S_UP));
        if (!bus.pos_valid) begin
            state_s = state_r;
        end else if (q_ext_s >= P_COUNT) begin
            led_s    = LED_ZERO;
            state_s  = ST_IDLE;
            run_s    = RUN_ZERO;
            cand_s   = M_NONE;
            locked_s = 1'b0;
            mode_s   = M_NONE;
            step_err_s = (state_r == ST_LOCK);
        end else if (state_r == ST_IDLE) begin
            prev_s  = bus.position;
            led_s   = LED_ONE << bus.position;
            state_s = ST_ACQ;
            run_s   = RUN_ZERO;
            cand_s  = M_NONE;
        end else if (cls_s == S_REP) begin
            state_s = state_r;
        end else begin
            prev_s = bus.position;
            led_s  = LED_ONE << bus.position;
            if (cls_s == S_UP || cls_s == S_WUP) dir_up_s = 1'b1;
            else if (cls_s == S_DN || cls_s == S_WDN) dir_up_s = 1'b0;
            else dir_up_s = dir_up_r;
            if (ok_s || upg_s) begin
                cand_s = upg_s ? M_BNC : cand_r;
                run_s  = (run_r >= RUN_LOCK) ? RUN_LOCK : run_r + RUN_ONE;
                if (state_r == ST_LOCK) mode_s = cand_s;
                else mode_s = M_NONE;
            end else begin
                step_err_s = (state_r == ST_LOCK);
                locked_s   = 1'b0;
                mode_s     = M_NONE;
                state_s    = ST_ACQ;
                cand_s     = seed_mode(cls_s);
                run_s      = (cand_s == M_NONE) ? RUN_ZERO : RUN_ONE;
            end
            if (state_s == ST_ACQ && cand_s != M_NONE && run_s == RUN_LOCK) begin
                state_s  = ST_LOCK;
                locked_s = 1'b1;
                mode_s   = cand_s;
            end else begin
                locked_s = locked_s;
            end
        end
    end

    // Pattern tracking state and registered outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r    <= ST_IDLE;
            prev_r     <= {POS_W{1'b0}};
            led_r      <= LED_ZERO;
            mode_r     <= M_NONE;
            cand_r     <= M_NONE;
            run_r      <= RUN_ZERO;
            dir_up_r   <= 1'b1;
            locked_r   <= 1'b0;
            step_err_r <= 1'b0;
        end else begin
            state_r    <= state_s;
            prev_r     <= prev_s;
            led_r      <= led_s;
            mode_r     <= mode_s;
            cand_r     <= cand_s;
            run_r      <= run_s;
            dir_up_r   <= dir_up_s;
            locked_r   <= locked_s;
            step_err_r <= step_err_s;
        end
    end

`ifdef DANCE_DEC_ERRCNT_EN
    logic [7:0] err_count_r;

    // Saturating count of step errors; holds at 255.
    always_ff @(posedge clock) begin
        if (reset) begin
            err_count_r <= 8'h00;
        end else if (step_err_s && err_count_r != 8'hFF) begin
            err_count_r <= err_count_r + 8'h01;
        end else begin
            err_count_r <= err_count_r;
        end
    end

    assign bus.err_count = err_count_r;
`else
    assign bus.err_count = 8'h00;
`endif

    assign bus.led      = led_r;
    assign bus.mode     = mode_r;
    assign bus.locked   = locked_r;
    assign bus.step_err = step_err_r;
endmodule

// File: tb/tb_dance_decoder.sv
// Scoreboard bench for dance_decoder: directed positions with hand-computed expected status.
module tb_dance_decoder;
    localparam int N  = 18;
    localparam int PW = 5;

    typedef struct packed {
        logic [N-1:0] led;
        logic [1:0]   mode;
        logic         locked;
        logic         step_err;
        logic [7:0]   err_count;
    } exp_t;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    dance_decoder_if #(.NUM_LEDS(N), .POS_W(PW)) bus ();
    dance_decoder #(.NUM_LEDS(N), .POS_W(PW), .LOCK_COUNT(4)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    exp_t        exp_q[$];
    string       name_q[$];
    int          checks   = 0;
    int          failures = 0;
    int          exp_errs = 0;
    logic [N-1:0] exp_led = '0;

    function automatic logic [7:0] exp_cnt();
`ifdef DANCE_DEC_ERRCNT_EN
        return 8'(exp_errs);
`else
        return 8'h00;
`endif
    endfunction

    task automatic push(input logic [1:0] m, input logic lk, input logic se, input string nm);
        exp_t e;
        e.led = exp_led; e.mode = m; e.locked = lk; e.step_err = se; e.err_count = exp_cnt();
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    task automatic step(input logic v, input int pos, input logic [1:0] m,
                        input logic lk, input logic se, input string nm);
        logic [N-1:0] one;
        one = 1;
        @(negedge clock);
        reset = 1'b0;
        bus.pos_valid = v;
        bus.position  = pos[PW-1:0];
        if (v) exp_led = (pos < N) ? (one << pos) : '0;
        if (se && exp_errs < 255) exp_errs++;
        push(m, lk, se, nm);
    endtask

    task automatic do_reset(input logic v);
        @(negedge clock);
        reset = 1'b1;
        bus.pos_valid = v;
        bus.position  = 5'd7;
        exp_led  = '0;
        exp_errs = 0;
        push(2'd3, 1'b0, 1'b0, "reset");
    endtask

    // Monitor: one scoreboard entry per sampled edge.
    initial begin
        exp_t  e;
        exp_t  got;
        string nm;
        forever begin
            @(posedge clock);
            #1;
            if (exp_q.size() > 0) begin
                e  = exp_q.pop_front();
                nm = name_q.pop_front();
                got = {bus.led, bus.mode, bus.locked, bus.step_err, bus.err_count};
                checks++;
                if (got !== e) begin
                    failures++;
                    $display("FAIL %s: got led=%h mode=%0d locked=%b step_err=%b err_count=%0d, want led=%h mode=%0d locked=%b step_err=%b err_count=%0d",
                             nm, got.led, got.mode, got.locked, got.step_err, got.err_count,
                             e.led, e.mode, e.locked, e.step_err, e.err_count);
                end
            end
        end
    end

    initial begin
        int pos;
        bus.pos_valid = 1'b0;
        bus.position  = 5'd0;

        // Ascending lock from 0.
        do_reset(1'b0);
        for (int i = 0; i < 4; i++) step(1'b1, i, 2'd3, 1'b0, 1'b0, "asc_acq");
        step(1'b1, 4, 2'd0, 1'b1, 1'b0, "asc_lock");

        // Descending lock across the 0 -> 17 wrap.
        do_reset(1'b0);
        step(1'b1, 3, 2'd3, 1'b0, 1'b0, "desc_acq");
        step(1'b1, 2, 2'd3, 1'b0, 1'b0, "desc_acq");
        step(1'b1, 1, 2'd3, 1'b0, 1'b0, "desc_acq");
        step(1'b1, 0, 2'd3, 1'b0, 1'b0, "desc_acq");
        step(1'b1, 17, 2'd1, 1'b1, 1'b0, "desc_wdn_lock");
        step(1'b1, 16, 2'd1, 1'b1, 1'b0, "desc_hold");

        // Ascending lock, then turn at the top becomes bounce.
        do_reset(1'b0);
        for (int i = 13; i < 17; i++) step(1'b1, i, 2'd3, 1'b0, 1'b0, "bnc_acq");
        step(1'b1, 17, 2'd0, 1'b1, 1'b0, "bnc_asc_lock");
        step(1'b1, 16, 2'd2, 1'b1, 1'b0, "bnc_upgrade");
        step(1'b1, 15, 2'd2, 1'b1, 1'b0, "bnc_down");
        step(1'b1, 14, 2'd2, 1'b1, 1'b0, "bnc_down2");
        step(1'b0, 3, 2'd2, 1'b1, 1'b0, "hold_invalid");
        step(1'b0, 20, 2'd2, 1'b1, 1'b0, "hold_invalid2");
        step(1'b1, 20, 2'd3, 1'b0, 1'b1, "oor_locked");

        // Violation while locked, then re-lock.
        do_reset(1'b0);
        for (int i = 1; i < 5; i++) step(1'b1, i, 2'd3, 1'b0, 1'b0, "viol_acq");
        step(1'b1, 5, 2'd0, 1'b1, 1'b0, "viol_lock");
        step(1'b1, 9, 2'd3, 1'b0, 1'b1, "viol_err");
        step(1'b1, 10, 2'd3, 1'b0, 1'b0, "relock_acq");
        step(1'b1, 11, 2'd3, 1'b0, 1'b0, "relock_acq");
        step(1'b1, 12, 2'd3, 1'b0, 1'b0, "relock_acq");
        step(1'b1, 13, 2'd0, 1'b1, 1'b0, "relock");

        // Repeats are ignored; out-of-range while locked returns to IDLE.
        do_reset(1'b0);
        step(1'b1, 2, 2'd3, 1'b0, 1'b0, "rep_idle");
        step(1'b1, 2, 2'd3, 1'b0, 1'b0, "rep");
        step(1'b1, 2, 2'd3, 1'b0, 1'b0, "rep");
        step(1'b1, 3, 2'd3, 1'b0, 1'b0, "rep_run1");
        step(1'b1, 3, 2'd3, 1'b0, 1'b0, "rep");
        step(1'b1, 4, 2'd3, 1'b0, 1'b0, "rep_run2");
        step(1'b1, 5, 2'd3, 1'b0, 1'b0, "rep_run3");
        step(1'b1, 6, 2'd0, 1'b1, 1'b0, "rep_lock");
        step(1'b1, 20, 2'd3, 1'b0, 1'b1, "oor_err");
        step(1'b1, 7, 2'd3, 1'b0, 1'b0, "after_oor_idle");
        step(1'b1, 8, 2'd3, 1'b0, 1'b0, "after_oor_acq");
        step(1'b1, 9, 2'd3, 1'b0, 1'b0, "after_oor_acq");
        step(1'b1, 10, 2'd3, 1'b0, 1'b0, "after_oor_acq");
        step(1'b1, 11, 2'd0, 1'b1, 1'b0, "after_oor_lock");

        // Reset beats pos_valid mid-lock.
        do_reset(1'b1);
        step(1'b1, 12, 2'd3, 1'b0, 1'b0, "post_reset_idle");

        // 300 violations, re-locking between each.
        do_reset(1'b0);
        for (int i = 0; i < 4; i++) step(1'b1, i, 2'd3, 1'b0, 1'b0, "sat_acq");
        step(1'b1, 4, 2'd0, 1'b1, 1'b0, "sat_lock");
        pos = 4;
        for (int v = 0; v < 300; v++) begin
            pos = (pos + 5) % N;
            step(1'b1, pos, 2'd3, 1'b0, 1'b1, "sat_err");
            for (int k = 0; k < 3; k++) begin
                pos = (pos + 1) % N;
                step(1'b1, pos, 2'd3, 1'b0, 1'b0, "sat_reacq");
            end
            pos = (pos + 1) % N;
            step(1'b1, pos, 2'd0, 1'b1, 1'b0, "sat_relock");
        end
        step(1'b0, 0, 2'd0, 1'b1, 1'b0, "sat_final");

        repeat (3) @(posedge clock);
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain: got %0d pending entries, want 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
